mem_initiator: RTL and testbench
================================

# mem_initiator

Requester-side engine for the translated memory block: accepts single commands (read, write, read-modify-write, TLB load) from an upstream client and drives the memory's read, write and TLB-load channels. It waits for each response, then returns one completion per command. It sits between test or CPU-side logic and the memory. Its memory-side ports connect name-for-name to the memory's ports. One command is in flight at a time, and a timeout guards against a hung responder.

## Interface
- VIRT_ADDR_WIDTH, 32: virtual address width.
- PHYS_ADDR_WIDTH, 28: physical base width for TLB loads.
- DATA_WIDTH, 64: data width; mask width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 64: maximum cycles spent waiting in any ISSUE or WAIT state; must be ≥ 1.
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid / cmd_ready  in / out  1  command handshake.
- cmd_op  in  2  command: 00 read, 01 write, 10 RMW, 11 TLB load.
- cmd_addr  in  VIRT_ADDR_WIDTH  virtual address; also the TLB virtual base.
- cmd_phys  in  PHYS_ADDR_WIDTH  TLB physical base.
- cmd_data / cmd_mask  in  DATA_WIDTH / DATA_WIDTH/8  write data and byte mask.
- cpl_valid / cpl_ready  out / in  1  completion handshake.
- cpl_op  out  2  echo of cmd_op.
- cpl_data  out  DATA_WIDTH  read data (read), merged data (RMW), 0 (write, TLB load).
- cpl_status  out  4  0 OK, 1 address error, 2 access error, F timeout.
- read_req_valid, read_req_addr, read_req_mask  out; read_req_ready  in: read request channel.
- read_resp_valid, read_resp_data, read_resp_status  in; read_resp_ready  out: read response channel.
- write_req_valid, write_req_addr, write_req_mask, write_req_data  out; write_req_ready  in: write request channel.
- write_resp_valid, write_resp_status  in; write_resp_ready  out: write response channel.
- tlb_load_valid, tlb_load_virt_base, tlb_load_phys_base  out; tlb_load_ready  in: TLB load channel.
- err_count  out  8  saturating count of completions with nonzero status.

## Operation
- States:
  - IDLE
  - RD_ISSUE, RD_WAIT
  - WR_ISSUE, WR_WAIT
  - TLB_ISSUE
  - CPL
- cmd_ready = 1 only in IDLE. On acceptance, all cmd_* fields are registered.
- IDLE transitions by op: read and RMW go to RD_ISSUE; write goes to WR_ISSUE; TLB load goes to TLB_ISSUE.
- ISSUE states:
  - The state's request valid is held high with stable payload until its ready is sampled high.
  - Read and write then move to the matching WAIT state; TLB_ISSUE moves to CPL with status 0.
- WAIT states:
  - The matching resp_ready is 1.
  - On resp_valid, data and status are captured in the same cycle.
- RD_WAIT exit:
  - Read: go to CPL.
  - RMW with status ≠ 0: go to CPL with that status; no write is issued.
  - RMW with status 0: merge, then go to WR_ISSUE. For each byte i, merged byte = cmd_mask[i] ? cmd_data byte : read byte. The write uses mask all-ones and data = merged.
- WR_WAIT exit: go to CPL with the write status.
- CPL: cpl_valid is held with stable fields until cpl_ready, then return to IDLE.
- Timeout:
  - A counter clears on entry to every ISSUE and WAIT state and increments each cycle spent there.
  - Reaching TIMEOUT_CYCLES goes to CPL with status F and deasserts the request valid. The valid drop without ready is permitted only here.
- Stale responses: in IDLE and CPL, both resp_ready outputs are 1 and any response is discarded. A response arriving late, after a new command has reached WAIT, is a known limitation and is not detected.
- err_count increments by 1 on each CPL handshake with status ≠ 0 and saturates at 255.

## Timing
- Reset state: IDLE. All outputs are 0, except read_resp_ready = 1, write_resp_ready = 1 and cmd_ready = 1 (IDLE behaviour). err_count = 0.
- Reset asserted mid-command aborts it with no completion. All request valids drop asynchronously.
- Latency against an always-ready, one-cycle responder, with command accepted at cycle 0:
  - Read: req valid at 1, response at 2, cpl_valid at 3.
  - Write: req valid at 1, response at 2, cpl_valid at 3.
  - RMW: read req at 1, write req at 3, cpl_valid at 5.
  - TLB load: tlb_load_valid at 1, cpl_valid at 2.
- Back-to-back: when the CPL handshake happens at cycle n, the next command can be accepted at n+1.
- Request address outputs carry cmd_addr unmodified. Reads use read_req_mask = cmd_mask.

## Test plan
- Load TLB with virt 0x0000_1000 → phys 0x0002000, then write 0x1122334455667788 mask FF at 0x1008, then read 0x1008: cpl_data = 0x1122334455667788, status 0 for all three completions, read cpl_valid 3 cycles after acceptance.
- Read at unmapped 0x0009_0000: cpl_status 1, cpl_data 0, err_count goes from 0 to 1, no write request issued.
- RMW at 0x1008 with data 0xAAAAAAAAAAAAAAAA, mask 0x0F: write_req_data = 0x11223344AAAAAAAA with mask FF; cpl_data equals that value; cpl_valid 5 cycles after acceptance.
- Hold read_req_ready = 0 with TIMEOUT_CYCLES = 8: read_req_valid drops after 8 cycles, cpl_status F.
- Hold cpl_ready low for 10 cycles: cpl fields are stable and cmd_ready stays 0 throughout. Separately, assert rst during WR_WAIT: all valids go 0 immediately, state is IDLE, and no completion is produced.
- Force 260 failing reads: err_count saturates at 255.

Source files
------------

// File: rtl/mem_initiator.sv
// Single-outstanding command engine for the translated memory block: turns
// read / write / read-modify-write / TLB-load commands into channel traffic.
module mem_initiator #(
    parameter int VIRT_ADDR_WIDTH = 32,
    parameter int PHYS_ADDR_WIDTH = 28,
    parameter int DATA_WIDTH      = 64,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_op,
    input  logic [VIRT_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [PHYS_ADDR_WIDTH-1:0] cmd_phys,
    input  logic [DATA_WIDTH-1:0]      cmd_data,
    input  logic [DATA_WIDTH/8-1:0]    cmd_mask,

    output logic                       cpl_valid,
    input  logic                       cpl_ready,
    output logic [1:0]                 cpl_op,
    output logic [DATA_WIDTH-1:0]      cpl_data,
    output logic [3:0]                 cpl_status,

    output logic                       read_req_valid,
    input  logic                       read_req_ready,
    output logic [VIRT_ADDR_WIDTH-1:0] read_req_addr,
    output logic [DATA_WIDTH/8-1:0]    read_req_mask,
    input  logic                       read_resp_valid,
    output logic                       read_resp_ready,
    input  logic [DATA_WIDTH-1:0]      read_resp_data,
    input  logic [3:0]                 read_resp_status,

    output logic                       write_req_valid,
    input  logic                       write_req_ready,
    output logic [VIRT_ADDR_WIDTH-1:0] write_req_addr,
    output logic [DATA_WIDTH/8-1:0]    write_req_mask,
    output logic [DATA_WIDTH-1:0]      write_req_data,
    input  logic                       write_resp_valid,
    output logic                       write_resp_ready,
    input  logic [3:0]                 write_resp_status,

    output logic                       tlb_load_valid,
    input  logic                       tlb_load_ready,
    output logic [VIRT_ADDR_WIDTH-1:0] tlb_load_virt_base,
    output logic [PHYS_ADDR_WIDTH-1:0] tlb_load_phys_base,

    output logic [7:0]                 err_count
);

    localparam int MASK_W = DATA_WIDTH / 8;
    localparam int CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_RMW   = 2'b10,
        OP_TLB   = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WR_ISSUE,
        WR_WAIT,
        TLB_ISSUE,
        CPL
    } state_t;

    state_t                     state, next_state;
    op_t                        op_q;
    logic [VIRT_ADDR_WIDTH-1:0] addr_q;
    logic [PHYS_ADDR_WIDTH-1:0] phys_q;
    logic [DATA_WIDTH-1:0]      data_q;
    logic [MASK_W-1:0]          mask_q;
    logic [DATA_WIDTH-1:0]      cpl_data_q;
    logic [3:0]                 cpl_status_q;
    logic [CNT_W-1:0]           tmo_cnt;
    logic                       tmo_hit;
    logic                       tmo_fire;
    logic                       timed_state;
    logic [DATA_WIDTH-1:0]      merged;

    assign tmo_hit     = (tmo_cnt == TMO_LAST);
    assign timed_state = state inside {RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, TLB_ISSUE};

    // Command bytes win where the mask is set; the rest come from the read.
    always_comb begin
        merged = read_resp_data;
        for (int i = 0; i < MASK_W; i++) begin
            if (mask_q[i]) merged[8*i +: 8] = data_q[8*i +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        next_state       = state;
        tmo_fire         = 1'b0;
        cmd_ready        = 1'b0;
        cpl_valid        = 1'b0;
        read_req_valid   = 1'b0;
        read_resp_ready  = 1'b0;
        write_req_valid  = 1'b0;
        write_resp_ready = 1'b0;
        tlb_load_valid   = 1'b0;

        case (state)
            IDLE: begin
                cmd_ready        = 1'b1;
                read_resp_ready  = 1'b1;
                write_resp_ready = 1'b1;
                if (cmd_valid) begin
                    case (op_t'(cmd_op))
                        OP_WRITE: next_state = WR_ISSUE;
                        OP_TLB:   next_state = TLB_ISSUE;
                        default:  next_state = RD_ISSUE;
                    endcase
                end
            end
            RD_ISSUE: begin
                read_req_valid = 1'b1;
                if (read_req_ready) next_state = RD_WAIT;
                else if (tmo_hit) begin
                    next_state = CPL;
                    tmo_fire   = 1'b1;
                end
            end
            RD_WAIT: begin
                read_resp_ready = 1'b1;
                if (read_resp_valid) begin
                    if (op_q == OP_RMW && read_resp_status == 4'h0) next_state = WR_ISSUE;
                    else                                            next_state = CPL;
                end else if (tmo_hit) begin
                    next_state = CPL;
                    tmo_fire   = 1'b1;
                end
            end
            WR_ISSUE: begin
                write_req_valid = 1'b1;
                if (write_req_ready) next_state = WR_WAIT;
                else if (tmo_hit) begin
                    next_state = CPL;
                    tmo_fire   = 1'b1;
                end
            end
            WR_WAIT: begin
                write_resp_ready = 1'b1;
                if (write_resp_valid) next_state = CPL;
                else if (tmo_hit) begin
                    next_state = CPL;
                    tmo_fire   = 1'b1;
                end
            end
            TLB_ISSUE: begin
                tlb_load_valid = 1'b1;
                if (tlb_load_ready) next_state = CPL;
                else if (tmo_hit) begin
                    next_state = CPL;
                    tmo_fire   = 1'b1;
                end
            end
            CPL: begin
                cpl_valid        = 1'b1;
                read_resp_ready  = 1'b1;
                write_resp_ready = 1'b1;
                if (cpl_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath registers are reset too, so every payload output reads 0 after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q         <= OP_READ;
            addr_q       <= '0;
            phys_q       <= '0;
            data_q       <= '0;
            mask_q       <= '0;
            cpl_data_q   <= '0;
            cpl_status_q <= 4'h0;
        end else begin
            if (state == IDLE && cmd_valid) begin
                op_q         <= op_t'(cmd_op);
                addr_q       <= cmd_addr;
                phys_q       <= cmd_phys;
                data_q       <= cmd_data;
                mask_q       <= cmd_mask;
                cpl_data_q   <= '0;
                cpl_status_q <= 4'h0;
            end
            if (state == RD_WAIT && read_resp_valid) begin
                cpl_status_q <= read_resp_status;
                if (op_q == OP_RMW && read_resp_status == 4'h0) begin
                    cpl_data_q <= merged;
                    data_q     <= merged;
                    mask_q     <= '1;
                end else begin
                    cpl_data_q <= read_resp_data;
                end
            end
            if (state == WR_WAIT && write_resp_valid) cpl_status_q <= write_resp_status;
            if (tmo_fire) begin
                cpl_status_q <= 4'hF;
                cpl_data_q   <= '0;
            end
        end
    end

    // The timeout counter restarts on every state change, so each ISSUE/WAIT gets a full budget.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       tmo_cnt <= '0;
        else if (next_state != state)  tmo_cnt <= '0;
        else if (timed_state)          tmo_cnt <= tmo_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= 8'd0;
        end else if (state == CPL && cpl_ready && cpl_status_q != 4'h0 && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
        end
    end

    assign cpl_op             = op_q;
    assign cpl_data           = cpl_data_q;
    assign cpl_status         = cpl_status_q;
    assign read_req_addr      = addr_q;
    assign read_req_mask      = mask_q;
    assign write_req_addr     = addr_q;
    assign write_req_mask     = mask_q;
    assign write_req_data     = data_q;
    assign tlb_load_virt_base = addr_q;
    assign tlb_load_phys_base = phys_q;

endmodule

// File: tb/tb_mem_initiator.sv
// Directed bench for mem_initiator: a one-cycle responder with a single-entry
// 4 KB-page TLB and a sparse word memory stands in for the memory block.
module tb_mem_initiator;

    localparam int VA  = 32;
    localparam int PA  = 28;
    localparam int DW  = 64;
    localparam int MW  = DW / 8;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          cmd_valid, cmd_ready;
    logic [1:0]    cmd_op;
    logic [VA-1:0] cmd_addr;
    logic [PA-1:0] cmd_phys;
    logic [DW-1:0] cmd_data;
    logic [MW-1:0] cmd_mask;
    logic          cpl_valid, cpl_ready;
    logic [1:0]    cpl_op;
    logic [DW-1:0] cpl_data;
    logic [3:0]    cpl_status;
    logic          read_req_valid, read_req_ready;
    logic [VA-1:0] read_req_addr;
    logic [MW-1:0] read_req_mask;
    logic          read_resp_valid, read_resp_ready;
    logic [DW-1:0] read_resp_data;
    logic [3:0]    read_resp_status;
    logic          write_req_valid, write_req_ready;
    logic [VA-1:0] write_req_addr;
    logic [MW-1:0] write_req_mask;
    logic [DW-1:0] write_req_data;
    logic          write_resp_valid, write_resp_ready;
    logic [3:0]    write_resp_status;
    logic          tlb_load_valid, tlb_load_ready;
    logic [VA-1:0] tlb_load_virt_base;
    logic [PA-1:0] tlb_load_phys_base;
    logic [7:0]    err_count;

    mem_initiator #(
        .VIRT_ADDR_WIDTH(VA), .PHYS_ADDR_WIDTH(PA), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
        .cmd_phys(cmd_phys), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
        .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_op(cpl_op), .cpl_data(cpl_data),
        .cpl_status(cpl_status),
        .read_req_valid(read_req_valid), .read_req_ready(read_req_ready),
        .read_req_addr(read_req_addr), .read_req_mask(read_req_mask),
        .read_resp_valid(read_resp_valid), .read_resp_ready(read_resp_ready),
        .read_resp_data(read_resp_data), .read_resp_status(read_resp_status),
        .write_req_valid(write_req_valid), .write_req_ready(write_req_ready),
        .write_req_addr(write_req_addr), .write_req_mask(write_req_mask),
        .write_req_data(write_req_data),
        .write_resp_valid(write_resp_valid), .write_resp_ready(write_resp_ready),
        .write_resp_status(write_resp_status),
        .tlb_load_valid(tlb_load_valid), .tlb_load_ready(tlb_load_ready),
        .tlb_load_virt_base(tlb_load_virt_base), .tlb_load_phys_base(tlb_load_phys_base),
        .err_count(err_count)
    );

    int checks = 0;
    int errors = 0;

    // Responder model state
    bit            tlb_v = 1'b0;
    logic [VA-1:0] tlb_virt;
    logic [PA-1:0] tlb_phys;
    logic [DW-1:0] mem [int unsigned];
    bit            wr_hold = 1'b0;
    int            wr_req_count = 0;
    logic [VA-1:0] last_wr_addr, last_rd_addr;
    logic [DW-1:0] last_wr_data;
    logic [MW-1:0] last_wr_mask, last_rd_mask;
    bit            rsp_rf, rsp_wf, rsp_tf;
    logic [DW-1:0] rsp_rd, rsp_word;
    logic [3:0]    rsp_rs, rsp_ws;
    int unsigned   rsp_key;

    function automatic bit xlate(input logic [VA-1:0] va, output int unsigned key);
        key = 0;
        if (tlb_v && va[VA-1:12] == tlb_virt[VA-1:12]) begin
            key = 32'({7'd0, tlb_phys[PA-1:12], va[11:3]});
            return 1'b1;
        end
        return 1'b0;
    endfunction

    // Requests are sampled at the falling edge, responses driven just after the next rising edge.
    initial begin
        read_resp_valid   = 1'b0;
        read_resp_data    = '0;
        read_resp_status  = 4'h0;
        write_resp_valid  = 1'b0;
        write_resp_status = 4'h0;
        forever begin
            @(negedge clk);
            rsp_rf = read_req_valid && read_req_ready;
            rsp_wf = write_req_valid && write_req_ready;
            rsp_tf = tlb_load_valid && tlb_load_ready;
            rsp_rd = '0;
            rsp_rs = 4'h0;
            rsp_ws = 4'h0;
            if (rsp_rf) begin
                last_rd_addr = read_req_addr;
                last_rd_mask = read_req_mask;
                if (xlate(read_req_addr, rsp_key)) rsp_rd = mem.exists(rsp_key) ? mem[rsp_key] : '0;
                else rsp_rs = 4'h1;
            end
            if (rsp_wf) begin
                wr_req_count++;
                last_wr_addr = write_req_addr;
                last_wr_data = write_req_data;
                last_wr_mask = write_req_mask;
                if (xlate(write_req_addr, rsp_key)) begin
                    rsp_word = mem.exists(rsp_key) ? mem[rsp_key] : '0;
                    for (int b = 0; b < MW; b++)
                        if (write_req_mask[b]) rsp_word[8*b +: 8] = write_req_data[8*b +: 8];
                    mem[rsp_key] = rsp_word;
                end else begin
                    rsp_ws = 4'h1;
                end
            end
            if (rsp_tf) begin
                tlb_v    = 1'b1;
                tlb_virt = tlb_load_virt_base;
                tlb_phys = tlb_load_phys_base;
            end
            @(posedge clk);
            #1;
            read_resp_valid   = rsp_rf;
            read_resp_data    = rsp_rd;
            read_resp_status  = rsp_rs;
            write_resp_valid  = rsp_wf && !wr_hold;
            write_resp_status = rsp_ws;
        end
    end

    // Drives a command and returns how many falling edges passed before cmd_ready was seen.
    task automatic issue_cmd(input logic [1:0] op, input logic [VA-1:0] addr, input logic [PA-1:0] phys,
                             input logic [DW-1:0] data, input logic [MW-1:0] mask, output int waited);
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_phys  = phys;
        cmd_data  = data;
        cmd_mask  = mask;
        cmd_valid = 1'b1;
        waited    = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!cmd_ready && waited < 50);
        checks++;
        if (!cmd_ready) begin
            errors++;
            $display("FAIL cmd_accept: cmd_ready=%0b after %0d cycles, required 1", cmd_ready, waited);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Returns the number of falling edges after acceptance until cpl_valid is seen.
    task automatic wait_cpl(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!cpl_valid && lat < 100);
        checks++;
        if (!cpl_valid) begin
            errors++;
            $display("FAIL cpl_wait: cpl_valid=%0b after %0d cycles, required 1", cpl_valid, lat);
        end
    endtask

    task automatic finish_cpl();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({cmd_ready, read_resp_ready, write_resp_ready} !== 3'b111) begin
            errors++;
            $display("FAIL reset_readies: got %b required 111", {cmd_ready, read_resp_ready, write_resp_ready});
        end
        checks++;
        if ({cpl_valid, read_req_valid, write_req_valid, tlb_load_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_valids: got %b required 0000",
                     {cpl_valid, read_req_valid, write_req_valid, tlb_load_valid});
        end
        checks++;
        if (err_count !== 8'd0 || cpl_data !== '0 || cpl_status !== 4'h0 || read_req_addr !== '0) begin
            errors++;
            $display("FAIL reset_payload: err=%0d data=%h status=%h addr=%h required all 0",
                     err_count, cpl_data, cpl_status, read_req_addr);
        end
        rst = 1'b0;
        finish_cpl();
    endtask

    task automatic test_tlb_write_read();
        int w, lat;
        issue_cmd(2'b11, 32'h0000_1000, 28'h0002000, '0, '0, w);
        wait_cpl(lat);
        checks++;
        if (lat !== 2 || cpl_status !== 4'h0 || cpl_op !== 2'b11 || cpl_data !== '0) begin
            errors++;
            $display("FAIL tlb_cpl: lat=%0d status=%h op=%0d data=%h required 2/0/3/0", lat, cpl_status, cpl_op, cpl_data);
        end
        finish_cpl();

        issue_cmd(2'b01, 32'h0000_1008, '0, 64'h1122334455667788, 8'hFF, w);
        checks++;
        if (w !== 1) begin
            errors++;
            $display("FAIL back_to_back: accepted after %0d cycles, required 1", w);
        end
        wait_cpl(lat);
        checks++;
        if (lat !== 3 || cpl_status !== 4'h0 || cpl_op !== 2'b01 || cpl_data !== '0) begin
            errors++;
            $display("FAIL write_cpl: lat=%0d status=%h op=%0d data=%h required 3/0/1/0", lat, cpl_status, cpl_op, cpl_data);
        end
        checks++;
        if (last_wr_addr !== 32'h1008 || last_wr_mask !== 8'hFF || last_wr_data !== 64'h1122334455667788) begin
            errors++;
            $display("FAIL write_req: addr=%h mask=%h data=%h required 1008/ff/1122334455667788",
                     last_wr_addr, last_wr_mask, last_wr_data);
        end
        finish_cpl();

        issue_cmd(2'b00, 32'h0000_1008, '0, '0, 8'h3C, w);
        wait_cpl(lat);
        checks++;
        if (lat !== 3 || cpl_status !== 4'h0 || cpl_op !== 2'b00) begin
            errors++;
            $display("FAIL read_cpl: lat=%0d status=%h op=%0d required 3/0/0", lat, cpl_status, cpl_op);
        end
        checks++;
        if (cpl_data !== 64'h1122334455667788) begin
            errors++;
            $display("FAIL read_data: got %h required 1122334455667788", cpl_data);
        end
        checks++;
        if (last_rd_addr !== 32'h1008 || last_rd_mask !== 8'h3C) begin
            errors++;
            $display("FAIL read_req: addr=%h mask=%h required 1008/3c", last_rd_addr, last_rd_mask);
        end
        finish_cpl();
    endtask

    task automatic test_unmapped_read();
        int w, lat, wc0;
        checks++;
        if (err_count !== 8'd0) begin
            errors++;
            $display("FAIL unmapped_err_before: got %0d required 0", err_count);
        end
        wc0 = wr_req_count;
        issue_cmd(2'b00, 32'h0009_0000, '0, '0, 8'hFF, w);
        wait_cpl(lat);
        checks++;
        if (cpl_status !== 4'h1 || cpl_data !== '0) begin
            errors++;
            $display("FAIL unmapped_cpl: status=%h data=%h required 1/0", cpl_status, cpl_data);
        end
        finish_cpl();
        checks++;
        if (err_count !== 8'd1 || wr_req_count !== wc0) begin
            errors++;
            $display("FAIL unmapped_side: err=%0d writes=%0d required 1/%0d", err_count, wr_req_count, wc0);
        end
    endtask

    task automatic test_rmw();
        int w, lat;
        issue_cmd(2'b10, 32'h0000_1008, '0, 64'hAAAAAAAAAAAAAAAA, 8'h0F, w);
        wait_cpl(lat);
        checks++;
        if (lat !== 5 || cpl_status !== 4'h0 || cpl_op !== 2'b10) begin
            errors++;
            $display("FAIL rmw_cpl: lat=%0d status=%h op=%0d required 5/0/2", lat, cpl_status, cpl_op);
        end
        checks++;
        if (last_wr_data !== 64'h11223344AAAAAAAA || last_wr_mask !== 8'hFF) begin
            errors++;
            $display("FAIL rmw_write: data=%h mask=%h required 11223344aaaaaaaa/ff", last_wr_data, last_wr_mask);
        end
        checks++;
        if (cpl_data !== 64'h11223344AAAAAAAA) begin
            errors++;
            $display("FAIL rmw_data: got %h required 11223344aaaaaaaa", cpl_data);
        end
        finish_cpl();
    endtask

    task automatic test_timeout();
        int w, hi;
        read_req_ready = 1'b0;
        issue_cmd(2'b00, 32'h0000_1008, '0, '0, 8'hFF, w);
        hi = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (cpl_valid) break;
            if (read_req_valid) hi++;
        end
        checks++;
        if (hi !== TMO || cpl_valid !== 1'b1 || read_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_valid: high=%0d cpl=%0b req=%0b required %0d/1/0", hi, cpl_valid, read_req_valid, TMO);
        end
        checks++;
        if (cpl_status !== 4'hF) begin
            errors++;
            $display("FAIL timeout_status: got %h required f", cpl_status);
        end
        read_req_ready = 1'b1;
        finish_cpl();
        checks++;
        if (err_count !== 8'd2) begin
            errors++;
            $display("FAIL timeout_err: got %0d required 2", err_count);
        end
    endtask

    task automatic test_cpl_stall();
        int w, lat;
        cpl_ready = 1'b0;
        issue_cmd(2'b00, 32'h0000_1008, '0, '0, 8'hFF, w);
        wait_cpl(lat);
        repeat (10) begin
            @(negedge clk);
            checks++;
            if (cpl_valid !== 1'b1 || cmd_ready !== 1'b0 || cpl_op !== 2'b00 ||
                cpl_status !== 4'h0 || cpl_data !== 64'h11223344AAAAAAAA) begin
                errors++;
                $display("FAIL cpl_stall: valid=%0b cmd_ready=%0b op=%0d status=%h data=%h required 1/0/0/0/11223344aaaaaaaa",
                         cpl_valid, cmd_ready, cpl_op, cpl_status, cpl_data);
            end
        end
        cpl_ready = 1'b1;
        finish_cpl();
        checks++;
        if (cpl_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cpl_release: valid=%0b cmd_ready=%0b required 0/1", cpl_valid, cmd_ready);
        end
    endtask

    task automatic test_reset_mid_cmd();
        int w, seen;
        wr_hold = 1'b1;
        issue_cmd(2'b01, 32'h0000_1010, '0, 64'h5A, 8'h01, w);
        @(posedge clk);
        #2;
        checks++;
        if (write_resp_ready !== 1'b1 || write_req_valid !== 1'b0 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL wr_wait_reached: resp_ready=%0b req_valid=%0b cmd_ready=%0b required 1/0/0",
                     write_resp_ready, write_req_valid, cmd_ready);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({cpl_valid, read_req_valid, write_req_valid, tlb_load_valid} !== 4'b0000 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: valids=%b cmd_ready=%0b required 0000/1",
                     {cpl_valid, read_req_valid, write_req_valid, tlb_load_valid}, cmd_ready);
        end
        checks++;
        if (err_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_err: got %0d required 0", err_count);
        end
        @(negedge clk);
        rst     = 1'b0;
        wr_hold = 1'b0;
        seen    = 0;
        repeat (10) begin
            @(negedge clk);
            if (cpl_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL reset_no_cpl: cpl_valid seen %0d cycles required 0", seen);
        end
        finish_cpl();
    endtask

    task automatic test_err_saturation();
        int w, lat;
        for (int i = 0; i < 260; i++) begin
            issue_cmd(2'b00, 32'h0009_0000, '0, '0, 8'hFF, w);
            wait_cpl(lat);
            finish_cpl();
            if (i == 253) begin
                checks++;
                if (err_count !== 8'd254) begin
                    errors++;
                    $display("FAIL err_count_254: got %0d required 254", err_count);
                end
            end
        end
        checks++;
        if (err_count !== 8'd255) begin
            errors++;
            $display("FAIL err_saturate: got %0d required 255", err_count);
        end
    endtask

    initial begin
        cmd_valid       = 1'b0;
        cmd_op          = 2'b00;
        cmd_addr        = '0;
        cmd_phys        = '0;
        cmd_data        = '0;
        cmd_mask        = '0;
        cpl_ready       = 1'b1;
        read_req_ready  = 1'b1;
        write_req_ready = 1'b1;
        tlb_load_ready  = 1'b1;

        test_reset();
        test_tlb_write_read();
        test_unmapped_read();
        test_rmw();
        test_timeout();
        test_cpl_stall();
        test_reset_mid_cmd();
        test_err_saturation();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1, "watchdog");
    end

endmodule
